// File: rtl/fsm_trace_checker.sv
// Trace checker for the five-state sequence FSM: predicts each next state code from the
// sampled code and input, records the first fault, and keeps visit and check counters.
module fsm_trace_checker #(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             a,
    input  logic [2:0]       code,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [15:0]      chk_cnt,
    output logic             err,
    output logic             err_pulse,
    output logic [1:0]       err_kind,
    output logic [2:0]       err_prev,
    output logic [2:0]       err_got,
    output logic             err_a,
    output logic [1:0]       st
);

    typedef enum logic [1:0] {IDLE = 2'd0, SYNC = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;
    typedef enum logic [1:0] {EK_NONE = 2'b00, EK_MISMATCH = 2'b01, EK_ILLEGAL = 2'b10} err_kind_t;

    function automatic logic is_legal(input logic [2:0] c);
        case (c)
            3'd2, 3'd3, 3'd4, 3'd6, 3'd7: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] next_code(input logic [2:0] c, input logic in_a);
        case (c)
            3'd2:    return 3'd4;
            3'd4:    return in_a ? 3'd3 : 3'd6;
            3'd6:    return 3'd7;
            3'd7:    return in_a ? 3'd4 : 3'd2;
            3'd3:    return 3'd6;
            default: return 3'd0;
        endcase
    endfunction

    state_t           state, state_n;
    err_kind_t        det_kind;
    logic             do_sample, do_check, code_legal;
    logic [2:0]       exp_code, prev_code;
    logic             prev_a;
    logic [CNT_W-1:0] visit [8];

    assign code_legal = is_legal(code);
    assign st         = state;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_n   = state;
        do_sample = 1'b0;
        do_check  = 1'b0;
        det_kind  = EK_NONE;
        case (state)
            IDLE: if (en) state_n = SYNC;
            SYNC: begin
                if (!en) begin
                    state_n = IDLE;
                end else if (code_legal) begin
                    do_sample = 1'b1;
                    state_n   = RUN;
                end else begin
                    det_kind = EK_ILLEGAL;
                end
            end
            RUN: begin
                if (!en) begin
                    state_n = IDLE;
                end else begin
                    do_check  = 1'b1;
                    do_sample = code_legal;
                    if (!code_legal)           det_kind = EK_ILLEGAL;
                    else if (code != exp_code) det_kind = EK_MISMATCH;
                end
            end
            HALT: ;
            default: state_n = IDLE;
        endcase
        // A mismatch resyncs in place; an illegal code needs a fresh legal sample first.
        if (det_kind != EK_NONE) begin
            if (STOP_ON_ERR)                 state_n = HALT;
            else if (det_kind == EK_ILLEGAL) state_n = SYNC;
        end
        if (clr) state_n = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            exp_code  <= '0;
            prev_code <= '0;
            prev_a    <= 1'b0;
            chk_cnt   <= '0;
            err       <= 1'b0;
            err_pulse <= 1'b0;
            err_kind  <= '0;
            err_prev  <= '0;
            err_got   <= '0;
            err_a     <= 1'b0;
            // NOTE: the visit array is only eight small counters, so it takes the async reset like any register.
            for (int i = 0; i < 8; i++) visit[i] <= '0;
        end else begin
            state     <= state_n;
            prev_code <= code;
            prev_a    <= a;
            err_pulse <= 1'b0;
            if (clr) begin
                exp_code <= '0;
                chk_cnt  <= '0;
                err      <= 1'b0;
                err_kind <= '0;
                err_prev <= '0;
                err_got  <= '0;
                err_a    <= 1'b0;
                for (int i = 0; i < 8; i++) visit[i] <= '0;
            end else begin
                if (do_check && chk_cnt != '1) chk_cnt <= chk_cnt + 16'd1;
                if (do_sample) begin
                    if (visit[code] != '1) visit[code] <= visit[code] + CNT_W'(1);
                    exp_code <= next_code(code, a);
                end
                if (det_kind != EK_NONE) begin
                    err       <= 1'b1;
                    err_pulse <= 1'b1;
                    if (!err) begin
                        err_kind <= det_kind;
                        err_prev <= prev_code;
                        err_got  <= code;
                        err_a    <= prev_a;
                    end
                end
            end
        end
    end

    always_comb begin
        rd_cnt = '0;
        if (is_legal(rd_sel)) rd_cnt = visit[rd_sel];
    end

endmodule

// File: tb/tb_fsm_trace_checker.sv
// Scoreboard bench: three checker instances (stop/8-bit, resync/8-bit, stop/2-bit) share
// one stimulus stream and are compared each cycle against a behavioural model.
module tb_fsm_trace_checker;

    typedef struct packed {
        logic [7:0]  rd;
        logic [15:0] chk;
        logic        err;
        logic        pulse;
        logic [1:0]  kind;
        logic [2:0]  prev;
        logic [2:0]  got;
        logic        ea;
        logic [1:0]  st;
    } obs_t;

    localparam int M_IDLE = 0, M_SYNC = 1, M_RUN = 2, M_HALT = 3;

    logic clk = 1'b0;
    logic reset = 1'b0, en = 1'b0, clr = 1'b0, a = 1'b0;
    logic [2:0] code = 3'd0, rd_sel = 3'd0;
    int n_checks = 0, n_errors = 0;

    logic [7:0]  d0_rd, d1_rd;
    logic [1:0]  d2_rd;
    logic [15:0] d0_chk, d1_chk, d2_chk;
    logic        d0_err, d1_err, d2_err, d0_pulse, d1_pulse, d2_pulse, d0_ea, d1_ea, d2_ea;
    logic [1:0]  d0_kind, d1_kind, d2_kind, d0_st, d1_st, d2_st;
    logic [2:0]  d0_prev, d1_prev, d2_prev, d0_got, d1_got, d2_got;
    obs_t        obs0, obs1, obs2;

    always #5 clk = ~clk;

    fsm_trace_checker #(.CNT_W(8), .STOP_ON_ERR(1'b1)) dut0 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .a(a), .code(code), .rd_sel(rd_sel),
        .rd_cnt(d0_rd), .chk_cnt(d0_chk), .err(d0_err), .err_pulse(d0_pulse), .err_kind(d0_kind),
        .err_prev(d0_prev), .err_got(d0_got), .err_a(d0_ea), .st(d0_st));
    fsm_trace_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0)) dut1 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .a(a), .code(code), .rd_sel(rd_sel),
        .rd_cnt(d1_rd), .chk_cnt(d1_chk), .err(d1_err), .err_pulse(d1_pulse), .err_kind(d1_kind),
        .err_prev(d1_prev), .err_got(d1_got), .err_a(d1_ea), .st(d1_st));
    fsm_trace_checker #(.CNT_W(2), .STOP_ON_ERR(1'b1)) dut2 (
        .clk(clk), .reset(reset), .en(en), .clr(clr), .a(a), .code(code), .rd_sel(rd_sel),
        .rd_cnt(d2_rd), .chk_cnt(d2_chk), .err(d2_err), .err_pulse(d2_pulse), .err_kind(d2_kind),
        .err_prev(d2_prev), .err_got(d2_got), .err_a(d2_ea), .st(d2_st));

    assign obs0 = {d0_rd, d0_chk, d0_err, d0_pulse, d0_kind, d0_prev, d0_got, d0_ea, d0_st};
    assign obs1 = {d1_rd, d1_chk, d1_err, d1_pulse, d1_kind, d1_prev, d1_got, d1_ea, d1_st};
    assign obs2 = {6'd0, d2_rd, d2_chk, d2_err, d2_pulse, d2_kind, d2_prev, d2_got, d2_ea, d2_st};

    // Reference model: one record per instance, indexed by instance number.
    int m_visit [3][8];
    int m_chk [3], m_kind [3], m_prev [3], m_got [3], m_ea [3];
    int m_mode [3], m_exp [3], m_pc [3], m_pa [3];
    bit m_err [3], m_pulse [3];
    obs_t q0[$], q1[$], q2[$];

    function automatic int f_next(int c, int av);
        case (c)
            2: return 4;
            4: return (av != 0) ? 3 : 6;
            6: return 7;
            7: return (av != 0) ? 4 : 2;
            3: return 6;
            default: return -1;
        endcase
    endfunction

    function automatic bit legal(int c);
        return f_next(c, 0) >= 0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 8; c++) m_visit[i][c] = 0;
            m_chk[i] = 0; m_kind[i] = 0; m_prev[i] = 0; m_got[i] = 0; m_ea[i] = 0;
            m_mode[i] = M_IDLE; m_exp[i] = 0; m_pc[i] = 0; m_pa[i] = 0;
            m_err[i] = 1'b0; m_pulse[i] = 1'b0;
        end
    endtask

    task automatic visit_inc(int i, int c);
        int cmax;
        cmax = (i == 2) ? 3 : 255;
        if (m_visit[i][c] < cmax) m_visit[i][c]++;
    endtask

    task automatic model_step(int i, bit c_clr, bit c_en, bit c_a, int c);
        int det;
        det = 0;
        m_pulse[i] = 1'b0;
        if (c_clr) begin
            for (int k = 0; k < 8; k++) m_visit[i][k] = 0;
            m_chk[i] = 0; m_err[i] = 1'b0; m_kind[i] = 0; m_prev[i] = 0;
            m_got[i] = 0; m_ea[i] = 0; m_exp[i] = 0; m_mode[i] = M_IDLE;
        end else begin
            if (m_mode[i] == M_IDLE) begin
                if (c_en) m_mode[i] = M_SYNC;
            end else if (m_mode[i] == M_SYNC) begin
                if (!c_en) m_mode[i] = M_IDLE;
                else if (legal(c)) begin
                    visit_inc(i, c);
                    m_exp[i] = f_next(c, int'(c_a));
                    m_mode[i] = M_RUN;
                end else det = 2;
            end else if (m_mode[i] == M_RUN) begin
                if (!c_en) m_mode[i] = M_IDLE;
                else begin
                    if (m_chk[i] < 65535) m_chk[i]++;
                    if (!legal(c)) det = 2;
                    else begin
                        if (c != m_exp[i]) det = 1;
                        visit_inc(i, c);
                        m_exp[i] = f_next(c, int'(c_a));
                    end
                end
            end
            if (det != 0) begin
                m_pulse[i] = 1'b1;
                if (!m_err[i]) begin
                    m_kind[i] = det; m_prev[i] = m_pc[i]; m_got[i] = c; m_ea[i] = m_pa[i];
                end
                m_err[i] = 1'b1;
                if (i != 1)      m_mode[i] = M_HALT;
                else if (det == 2) m_mode[i] = M_SYNC;
            end
        end
        m_pc[i] = c;
        m_pa[i] = int'(c_a);
    endtask

    function automatic obs_t expect_obs(int i, int sel);
        obs_t e;
        e.rd    = legal(sel) ? 8'(m_visit[i][sel]) : 8'd0;
        e.chk   = 16'(m_chk[i]);
        e.err   = m_err[i];
        e.pulse = m_pulse[i];
        e.kind  = 2'(m_kind[i]);
        e.prev  = 3'(m_prev[i]);
        e.got   = 3'(m_got[i]);
        e.ea    = 1'(m_ea[i]);
        e.st    = 2'(m_mode[i]);
        return e;
    endfunction

    task automatic cmp(int i, obs_t e, obs_t g);
        check($sformatf("d%0d.rd_cnt", i),    32'(g.rd),    32'(e.rd));
        check($sformatf("d%0d.chk_cnt", i),   32'(g.chk),   32'(e.chk));
        check($sformatf("d%0d.err", i),       32'(g.err),   32'(e.err));
        check($sformatf("d%0d.err_pulse", i), 32'(g.pulse), 32'(e.pulse));
        check($sformatf("d%0d.err_kind", i),  32'(g.kind),  32'(e.kind));
        check($sformatf("d%0d.err_prev", i),  32'(g.prev),  32'(e.prev));
        check($sformatf("d%0d.err_got", i),   32'(g.got),   32'(e.got));
        check($sformatf("d%0d.err_a", i),     32'(g.ea),    32'(e.ea));
        check($sformatf("d%0d.st", i),        32'(g.st),    32'(e.st));
    endtask

    // Driver: apply one edge worth of inputs and push the predicted response.
    task automatic cyc(bit c_clr, bit c_en, bit c_a, int c, int sel);
        @(negedge clk);
        clr = c_clr; en = c_en; a = c_a; code = 3'(c); rd_sel = 3'(sel);
        for (int i = 0; i < 3; i++) model_step(i, c_clr, c_en, c_a, c);
        q0.push_back(expect_obs(0, sel));
        q1.push_back(expect_obs(1, sel));
        q2.push_back(expect_obs(2, sel));
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    function automatic int rnd_sel();
        return int'($urandom_range(7, 0));
    endfunction

    // Monitor: every edge produces a response, compared just after the edge.
    initial begin
        obs_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin e = q0.pop_front(); cmp(0, e, obs0); end
            if (q1.size() > 0) begin e = q1.pop_front(); cmp(1, e, obs1); end
            if (q2.size() > 0) begin e = q2.pop_front(); cmp(2, e, obs2); end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic run_random(int cycles);
        int fsm_c, c;
        bit ra, ren, rclr;
        fsm_c = 2;
        for (int n = 0; n < cycles; n++) begin
            ra   = 1'($urandom_range(1, 0));
            ren  = $urandom_range(99, 0) < 95;
            rclr = $urandom_range(99, 0) < 3;
            c    = ($urandom_range(99, 0) < 8) ? int'($urandom_range(7, 0)) : fsm_c;
            cyc(rclr, ren, ra, c, rnd_sel());
            fsm_c = legal(c) ? f_next(c, int'(ra)) : 2;
        end
    endtask

    initial begin
        int seq_a0 [6] = '{2, 4, 6, 7, 2, 4};
        int seq_a1 [7] = '{2, 4, 3, 6, 7, 4, 3};
        int ring [4]   = '{2, 4, 6, 7};

        model_reset();
        #2 reset = 1'b1;
        #1;
        cmp(0, '0, obs0); cmp(1, '0, obs1); cmp(2, '0, obs2);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Legal stream, a=0.
        cyc(1'b0, 1'b1, 1'b0, 0, rnd_sel());
        foreach (seq_a0[k]) cyc(1'b0, 1'b1, 1'b0, seq_a0[k], (k == 5) ? 2 : rnd_sel());
        settle();
        check("a0.chk_cnt", 32'(d0_chk), 32'd5);
        check("a0.err", 32'(d0_err), 32'd0);
        check("a0.visit2", 32'(d0_rd), 32'd2);
        rd_sel = 3'd6; #1;
        check("a0.visit6", 32'(d0_rd), 32'd1);

        // Legal stream, a=1.
        cyc(1'b1, 1'b0, 1'b0, 0, rnd_sel());
        cyc(1'b0, 1'b1, 1'b1, 0, rnd_sel());
        foreach (seq_a1[k]) cyc(1'b0, 1'b1, 1'b1, seq_a1[k], (k == 6) ? 4 : rnd_sel());
        settle();
        check("a1.err", 32'(d0_err), 32'd0);
        check("a1.st", 32'(d0_st), 32'd2);
        check("a1.visit4", 32'(d0_rd), 32'd2);

        // Mismatch: code 4 with a=0, then 3.
        cyc(1'b1, 1'b0, 1'b0, 0, rnd_sel());
        cyc(1'b0, 1'b1, 1'b0, 0, rnd_sel());
        cyc(1'b0, 1'b1, 1'b0, 2, rnd_sel());
        cyc(1'b0, 1'b1, 1'b0, 4, rnd_sel());
        cyc(1'b0, 1'b1, 1'b0, 3, rnd_sel());
        settle();
        check("mm.pulse", 32'(d0_pulse), 32'd1);
        check("mm.kind", 32'(d0_kind), 32'd1);
        check("mm.prev", 32'(d0_prev), 32'd4);
        check("mm.got", 32'(d0_got), 32'd3);
        check("mm.st_halt", 32'(d0_st), 32'd3);
        cyc(1'b0, 1'b1, 1'b0, 6, rnd_sel());
        cyc(1'b0, 1'b1, 1'b0, 7, rnd_sel());
        settle();
        check("mm.chk_frozen", 32'(d0_chk), 32'd2);

        // Illegal code with resync (dut1), then a later mismatch.
        cyc(1'b1, 1'b0, 1'b0, 0, rnd_sel());
        cyc(1'b0, 1'b1, 1'b0, 0, rnd_sel());
        cyc(1'b0, 1'b1, 1'b0, 2, rnd_sel());
        cyc(1'b0, 1'b1, 1'b0, 4, rnd_sel());
        cyc(1'b0, 1'b1, 1'b0, 5, rnd_sel());
        settle();
        check("il.kind", 32'(d1_kind), 32'd2);
        check("il.st_sync", 32'(d1_st), 32'd1);
        cyc(1'b0, 1'b1, 1'b0, 6, rnd_sel());
        settle();
        check("il.st_run", 32'(d1_st), 32'd2);
        cyc(1'b0, 1'b1, 1'b0, 7, rnd_sel());
        cyc(1'b0, 1'b1, 1'b0, 4, rnd_sel());
        settle();
        check("il.pulse2", 32'(d1_pulse), 32'd1);
        check("il.kind_kept", 32'(d1_kind), 32'd2);
        check("il.got_kept", 32'(d1_got), 32'd5);

        // Saturation: six visits to code 2.
        cyc(1'b1, 1'b0, 1'b0, 0, rnd_sel());
        cyc(1'b0, 1'b1, 1'b0, 0, rnd_sel());
        for (int r = 0; r < 6; r++)
            foreach (ring[k]) cyc(1'b0, 1'b1, 1'b0, ring[k], (r == 5 && k == 3) ? 2 : rnd_sel());
        settle();
        check("sat.d2_visit2", 32'(d2_rd), 32'd3);
        check("sat.d0_visit2", 32'(d0_rd), 32'd6);
        rd_sel = 3'd5; #1;
        check("sat.sel5", 32'(d2_rd), 32'd0);

        // Asynchronous reset in the middle of RUN.
        cyc(1'b0, 1'b1, 1'b0, 2, rnd_sel());
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        cmp(0, '0, obs0); cmp(1, '0, obs1); cmp(2, '0, obs2);
        model_reset();
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 4, rnd_sel());

        // Clear out of HALT.
        cyc(1'b0, 1'b1, 1'b0, 0, rnd_sel());
        cyc(1'b0, 1'b1, 1'b0, 2, rnd_sel());
        cyc(1'b0, 1'b1, 1'b0, 6, rnd_sel());
        cyc(1'b1, 1'b1, 1'b0, 7, rnd_sel());
        settle();
        check("clr.st", 32'(d0_st), 32'd0);
        check("clr.err", 32'(d0_err), 32'd0);

        run_random(600);

        @(negedge clk);
        @(negedge clk);
        check("queue_drain", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
